// File: rtl/kmkz_ahb_arbiter.sv
// kmkz_ahb_arbiter
//   Two-master (I = instruction, D = data) to one-slave AHB-lite arbiter.
//   Single transfers only. A losing master's address phase is captured and
//   replayed later, and the master is stalled through its own HREADY.
//   Optional build macro KMKZ_AHB_ARB_PERF_EN adds PERF_WAIT_I / PERF_WAIT_D
//   wait-cycle counters.
module kmkz_ahb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] I_HADDR,
  input  logic [1:0]  I_HTRANS,
  input  logic [2:0]  I_HSIZE,
  input  logic [3:0]  I_HPROT,
  input  logic        I_HWRITE,
  input  logic        I_HMASTLOCK,
  input  logic [31:0] I_HWDATA,
  output logic [31:0] I_HRDATA,
  output logic        I_HREADY,
  output logic        I_HRESP,
  input  logic [31:0] D_HADDR,
  input  logic [1:0]  D_HTRANS,
  input  logic [2:0]  D_HSIZE,
  input  logic [3:0]  D_HPROT,
  input  logic        D_HWRITE,
  input  logic        D_HMASTLOCK,
  input  logic [31:0] D_HWDATA,
  output logic [31:0] D_HRDATA,
  output logic        D_HREADY,
  output logic        D_HRESP,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic [2:0]  S_HSIZE,
  output logic [3:0]  S_HPROT,
  output logic        S_HWRITE,
  output logic        S_HMASTLOCK,
  output logic [2:0]  S_HBURST,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP
`ifdef KMKZ_AHB_ARB_PERF_EN
  ,
  output logic [31:0] PERF_WAIT_I,
  output logic [31:0] PERF_WAIT_D
`endif
);

  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } own_t;

  typedef struct packed {
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hwrite;
    logic        hlock;
  } addr_ph_t;

  own_t             down_r;
  own_t             down_nxt_s;
  logic             pend_i_r;
  logic             pend_d_r;
  addr_ph_t         i_cap_r;
  addr_ph_t         d_cap_r;
  logic [STV_W-1:0] stv_cnt_r;

  addr_ph_t i_in_s;
  addr_ph_t d_in_s;
  addr_ph_t i_ph_s;
  addr_ph_t d_ph_s;
  addr_ph_t out_ph_s;
  logic     i_hready_s;
  logic     d_hready_s;
  logic     i_live_s;
  logic     d_live_s;
  logic     i_cand_s;
  logic     d_cand_s;
  logic     grant_i_s;
  logic     grant_d_s;
  logic     starve_hit_s;
  logic     unused_s;

  // Bit 0 of HTRANS is ignored: SEQ is handled exactly like NONSEQ.
  assign unused_s = ^{I_HTRANS[0], D_HTRANS[0]};

  assign i_in_s = '{haddr: I_HADDR, hsize: I_HSIZE, hprot: I_HPROT,
                    hwrite: I_HWRITE, hlock: I_HMASTLOCK};
  assign d_in_s = '{haddr: D_HADDR, hsize: D_HSIZE, hprot: D_HPROT,
                    hwrite: D_HWRITE, hlock: D_HMASTLOCK};

  // Per-master ready and response: the data-phase owner sees the slave, a
  // master with a pending replay is stalled, anyone else is free to issue.
  always_comb begin
    i_hready_s = 1'b1;
    d_hready_s = 1'b1;
    I_HRESP    = 1'b0;
    D_HRESP    = 1'b0;
    if (down_r == OWN_I) begin
      i_hready_s = S_HREADY;
      I_HRESP    = S_HRESP;
    end else begin
      i_hready_s = ~pend_i_r;
    end
    if (down_r == OWN_D) begin
      d_hready_s = S_HREADY;
      D_HRESP    = S_HRESP;
    end else begin
      d_hready_s = ~pend_d_r;
    end
  end

  assign I_HREADY = i_hready_s;
  assign D_HREADY = d_hready_s;
  assign I_HRDATA = S_HRDATA;
  assign D_HRDATA = S_HRDATA;
  assign S_HBURST = 3'b000;

  // Arbitration: D wins ties unless I has waited through STARVE_LIMIT D grants.
  always_comb begin
    i_live_s     = I_HTRANS[1] & i_hready_s & nRST;
    d_live_s     = D_HTRANS[1] & d_hready_s & nRST;
    i_cand_s     = pend_i_r | i_live_s;
    d_cand_s     = pend_d_r | d_live_s;
    starve_hit_s = (STARVE_LIMIT != 0) && (stv_cnt_r == STV_MAX);
    grant_i_s    = 1'b0;
    grant_d_s    = 1'b0;
    if (S_HREADY && nRST) begin
      if (i_cand_s && d_cand_s) begin
        if (starve_hit_s) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else if (i_cand_s) begin
        grant_i_s = 1'b1;
      end else if (d_cand_s) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
    end
  end

  // Slave address phase: the winner's replayed or live fields, else IDLE/zero.
  always_comb begin
    i_ph_s   = pend_i_r ? i_cap_r : i_in_s;
    d_ph_s   = pend_d_r ? d_cap_r : d_in_s;
    out_ph_s = '0;
    S_HTRANS = 2'b00;
    if (grant_i_s) begin
      out_ph_s = i_ph_s;
      S_HTRANS = 2'b10;
    end else if (grant_d_s) begin
      out_ph_s = d_ph_s;
      S_HTRANS = 2'b10;
    end else begin
      out_ph_s = '0;
      S_HTRANS = 2'b00;
    end
  end

  assign S_HADDR     = out_ph_s.haddr;
  assign S_HSIZE     = out_ph_s.hsize;
  assign S_HPROT     = out_ph_s.hprot;
  assign S_HWRITE    = out_ph_s.hwrite;
  assign S_HMASTLOCK = out_ph_s.hlock;

  // Write data follows whichever master owns the current data phase.
  always_comb begin
    case (down_r)
      OWN_I:   S_HWDATA = I_HWDATA;
      OWN_D:   S_HWDATA = D_HWDATA;
      default: S_HWDATA = 32'h0000_0000;
    endcase
  end

  // Next data-phase owner: advances only when the slave completes a phase.
  always_comb begin
    down_nxt_s = down_r;
    if (S_HREADY) begin
      if (grant_i_s) begin
        down_nxt_s = OWN_I;
      end else if (grant_d_s) begin
        down_nxt_s = OWN_D;
      end else begin
        down_nxt_s = OWN_NONE;
      end
    end else begin
      down_nxt_s = down_r;
    end
  end

  // Owner register, pending-request capture and starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      down_r    <= OWN_NONE;
      pend_i_r  <= 1'b0;
      pend_d_r  <= 1'b0;
      i_cap_r   <= '0;
      d_cap_r   <= '0;
      stv_cnt_r <= '0;
    end else begin
      down_r <= down_nxt_s;
      if (grant_i_s) begin
        pend_i_r <= 1'b0;
      end else if (i_live_s) begin
        pend_i_r <= 1'b1;
        i_cap_r  <= i_in_s;
      end
      if (grant_d_s) begin
        pend_d_r <= 1'b0;
      end else if (d_live_s) begin
        pend_d_r <= 1'b1;
        d_cap_r  <= d_in_s;
      end
      if (grant_d_s && i_cand_s) begin
        if (stv_cnt_r != STV_MAX) begin
          stv_cnt_r <= stv_cnt_r + STV_W'(1);
        end
      end else if (grant_i_s) begin
        stv_cnt_r <= '0;
      end
    end
  end

`ifdef KMKZ_AHB_ARB_PERF_EN
  logic [31:0] perf_wait_i_r;
  logic [31:0] perf_wait_d_r;

  // Saturating count of cycles each master spends with a pending replay.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_wait_i_r <= 32'h0000_0000;
      perf_wait_d_r <= 32'h0000_0000;
    end else begin
      if (pend_i_r && (perf_wait_i_r != 32'hFFFF_FFFF)) begin
        perf_wait_i_r <= perf_wait_i_r + 32'd1;
      end
      if (pend_d_r && (perf_wait_d_r != 32'hFFFF_FFFF)) begin
        perf_wait_d_r <= perf_wait_d_r + 32'd1;
      end
    end
  end

  assign PERF_WAIT_I = perf_wait_i_r;
  assign PERF_WAIT_D = perf_wait_d_r;
`endif

endmodule
